// File: rtl/fp32mul_out_stage_if.sv
// Handshake/bus bundle between the FP32 multiplier output stage and its neighbours.
// master = upstream producer/consumer side, slave = the output stage itself.
interface fp32mul_out_stage_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [31:0]      in_z;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_z;
    logic [4:0]       out_flags;
    logic             clr_sticky;
    logic [4:0]       sticky_flags;
    logic [CNT_W-1:0] nan_count;

    modport master (
        output in_valid, in_a, in_b, in_z, out_ready, clr_sticky,
        input  in_ready, out_valid, out_z, out_flags, sticky_flags, nan_count
    );

    modport slave (
        input  in_valid, in_a, in_b, in_z, out_ready, clr_sticky,
        output in_ready, out_valid, out_z, out_flags, sticky_flags, nan_count
    );
endinterface

// File: rtl/fp32mul_out_stage.sv
// Registered output stage for the FP32 multiplier: classifies each product, optionally
// canonicalises NaNs, and delivers through a 2-entry skid buffer with sticky flags.
module fp32mul_out_stage #(
    parameter int CANON_NAN = 1,
    parameter int CNT_W     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    fp32mul_out_stage_if.slave  bus
);
    typedef struct packed {
        logic [31:0] z;
        logic [4:0]  flags;  // {invalid, nan, inf, zero, denorm}
    } entry_t;

    localparam logic [31:0] QNAN = 32'h7fc0_0000;

    function automatic logic is_inf(input logic [31:0] v);
        return (v[30:23] == 8'hff) && (v[22:0] == 23'd0);
    endfunction

    function automatic logic is_zero(input logic [31:0] v);
        return (v[30:23] == 8'h00) && (v[22:0] == 23'd0);
    endfunction

    function automatic logic is_snan(input logic [31:0] v);
        return (v[30:23] == 8'hff) && (v[22:0] != 23'd0) && !v[22];
    endfunction

    entry_t           hd_q, hd_d, tl_q, tl_d, new_e;
    logic [1:0]       occ_q, occ_d;
    logic [4:0]       sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
    logic             push, pop, z_nan, z_inf, z_zero, z_den, invalid;

    always_comb begin
        z_nan   = (bus.in_z[30:23] == 8'hff) && (bus.in_z[22:0] != 23'd0);
        z_inf   = is_inf(bus.in_z);
        z_zero  = is_zero(bus.in_z);
        z_den   = (bus.in_z[30:23] == 8'h00) && (bus.in_z[22:0] != 23'd0);
        invalid = (is_inf(bus.in_a) && is_zero(bus.in_b)) || (is_zero(bus.in_a) && is_inf(bus.in_b))
                  || is_snan(bus.in_a) || is_snan(bus.in_b);
        new_e.flags = {invalid, z_nan, z_inf, z_zero, z_den};
        // Flags always reflect the raw product; only the stored value is canonicalised.
        new_e.z     = ((CANON_NAN != 0) && z_nan) ? QNAN : bus.in_z;

        push = bus.in_valid && (occ_q != 2'd2);
        pop  = (occ_q != 2'd0) && bus.out_ready;

        hd_d  = hd_q;
        tl_d  = tl_q;
        occ_d = occ_q + {1'b0, push} - {1'b0, pop};
        // Head only changes when it is refilled, so out_z holds its last value when empty.
        if (pop) begin
            if (occ_q == 2'd2)  hd_d = tl_q;
            else if (push)      hd_d = new_e;
        end else if (push) begin
            if (occ_q == 2'd0)  hd_d = new_e;
            else                tl_d = new_e;
        end

        sticky_d = (bus.clr_sticky ? 5'd0 : sticky_q) | (pop ? hd_q.flags : 5'd0);
        cnt_base = bus.clr_sticky ? '0 : cnt_q;
        cnt_d    = cnt_base;
        if (pop && hd_q.flags[3] && (cnt_base != {CNT_W{1'b1}}))
            cnt_d = cnt_base + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hd_q     <= '0;
            tl_q     <= '0;
            occ_q    <= 2'd0;
            sticky_q <= 5'd0;
            cnt_q    <= '0;
        end else begin
            hd_q     <= hd_d;
            tl_q     <= tl_d;
            occ_q    <= occ_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.in_ready     = (occ_q != 2'd2);
    assign bus.out_valid    = (occ_q != 2'd0);
    assign bus.out_z        = hd_q.z;
    assign bus.out_flags    = hd_q.flags;
    assign bus.sticky_flags = sticky_q;
    assign bus.nan_count    = cnt_q;
endmodule

// File: tb/tb_fp32mul_out_stage.sv
// Bench for fp32mul_out_stage: two instances (canonicalising/8-bit counter and
// pass-through/2-bit counter) fed identical stimulus and checked against a queue model.
module tb_fp32mul_out_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0, out_ready = 1'b0, clr_sticky = 1'b0;
    logic [31:0] in_a = '0, in_b = '0, in_z = '0;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    fp32mul_out_stage_if #(.CNT_W(8)) b0 ();
    fp32mul_out_stage_if #(.CNT_W(2)) b1 ();

    assign b0.in_valid = in_valid;   assign b1.in_valid = in_valid;
    assign b0.in_a = in_a;           assign b1.in_a = in_a;
    assign b0.in_b = in_b;           assign b1.in_b = in_b;
    assign b0.in_z = in_z;           assign b1.in_z = in_z;
    assign b0.out_ready = out_ready; assign b1.out_ready = out_ready;
    assign b0.clr_sticky = clr_sticky; assign b1.clr_sticky = clr_sticky;

    fp32mul_out_stage #(.CANON_NAN(1), .CNT_W(8)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    fp32mul_out_stage #(.CANON_NAN(0), .CNT_W(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    typedef struct { logic [31:0] z; logic [4:0] f; } ent_t;
    ent_t q[$];
    logic [4:0] m_sticky = '0;
    int m_cnt0 = 0, m_cnt1 = 0;
    bit m_pushed;

    // Reference classification, written directly from the IEEE-754 field definitions.
    function automatic logic [4:0] classify(input logic [31:0] a, b, z);
        int ea = a[30:23], eb = b[30:23], ez = z[30:23];
        int ma = a[22:0], mb = b[22:0], mz = z[22:0];
        bit a_inf = (ea == 255) && (ma == 0), b_inf = (eb == 255) && (mb == 0);
        bit a_zero = (ea == 0) && (ma == 0), b_zero = (eb == 0) && (mb == 0);
        bit a_snan = (ea == 255) && (ma != 0) && (ma < (1 << 22));
        bit b_snan = (eb == 255) && (mb != 0) && (mb < (1 << 22));
        bit inv = (a_inf && b_zero) || (a_zero && b_inf) || a_snan || b_snan;
        return {inv, (ez == 255) && (mz != 0), (ez == 255) && (mz == 0),
                (ez == 0) && (mz == 0), (ez == 0) && (mz != 0)};
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic s = 1'($urandom);
        case ($urandom_range(0, 5))
            0: return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
            1: return {s, 31'd0};
            2: return {s, 8'hff, 23'd0};
            3: return {s, 8'hff, 1'b1, 22'($urandom)};
            4: return {s, 8'hff, 1'b0, 22'($urandom_range(1, 4194303))};
            default: return {s, 8'h00, 23'($urandom_range(1, 8388607))};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        bit v = (q.size() != 0);
        chk("out_valid0", 32'(b0.out_valid), 32'(v));
        chk("out_valid1", 32'(b1.out_valid), 32'(v));
        chk("in_ready0", 32'(b0.in_ready), 32'(q.size() < 2));
        chk("in_ready1", 32'(b1.in_ready), 32'(q.size() < 2));
        chk("sticky0", 32'(b0.sticky_flags), 32'(m_sticky));
        chk("sticky1", 32'(b1.sticky_flags), 32'(m_sticky));
        chk("nan_count0", 32'(b0.nan_count), 32'(m_cnt0));
        chk("nan_count1", 32'(b1.nan_count), 32'(m_cnt1));
        if (v) begin
            chk("out_z0", b0.out_z, q[0].f[3] ? 32'h7fc00000 : q[0].z);
            chk("out_z1", b1.out_z, q[0].z);
            chk("out_flags0", 32'(b0.out_flags), 32'(q[0].f));
            chk("out_flags1", 32'(b1.out_flags), 32'(q[0].f));
        end
    endtask

    // One clock: model advances on the rising edge, outputs are compared on the falling edge.
    task automatic cycle();
        bit pop, push;
        int c0, c1;
        ent_t e;
        @(posedge clk);
        m_pushed = 0;
        if (rst_n) begin
            pop  = (q.size() > 0) && out_ready;
            push = in_valid && (q.size() < 2);
            c0 = clr_sticky ? 0 : m_cnt0;
            c1 = clr_sticky ? 0 : m_cnt1;
            m_sticky = (clr_sticky ? 5'd0 : m_sticky) | (pop ? q[0].f : 5'd0);
            if (pop && q[0].f[3]) begin c0++; c1++; end
            m_cnt0 = (c0 > 255) ? 255 : c0;
            m_cnt1 = (c1 > 3) ? 3 : c1;
            if (pop) void'(q.pop_front());
            if (push) begin
                e.z = in_z;
                e.f = classify(in_a, in_b, in_z);
                q.push_back(e);
                m_pushed = 1;
            end
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input logic v, input logic [31:0] a, b, z);
        in_valid = v; in_a = a; in_b = b; in_z = z;
    endtask

    task automatic push_held(input logic [31:0] a, b, z);
        bit done = 0;
        drive(1'b1, a, b, z);
        for (int i = 0; i < 10 && !done; i++) begin
            cycle();
            done = m_pushed;
        end
        chk("push_accepted", 32'(done), 32'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        check_all();
        chk("reset_out_z0", b0.out_z, 32'd0);
        chk("reset_out_flags0", 32'(b0.out_flags), 32'd0);
        cycle();
        rst_n = 1'b1;

        // Basic: 1.5 * 2.0 = 3.0
        out_ready = 1'b1;
        drive(1'b1, 32'h3fc00000, 32'h40000000, 32'h40400000);
        cycle();
        chk("basic_z", b0.out_z, 32'h40400000);
        chk("basic_flags", 32'(b0.out_flags), 32'd0);
        in_valid = 1'b0;
        cycle();

        // Invalid: Inf * 0, then -Inf * 3
        drive(1'b1, 32'h7f800000, 32'h00000000, 32'h7fc00000);
        cycle();
        chk("inv_flags", 32'(b0.out_flags), 32'b11000);
        drive(1'b1, 32'hff800000, 32'h40400000, 32'hff800000);
        cycle();
        chk("inv_sticky", 32'(b0.sticky_flags), 32'b11000);
        chk("inv_count", 32'(b0.nan_count), 32'd1);
        chk("inf_flags", 32'(b0.out_flags), 32'b00100);
        in_valid = 1'b0;
        cycle();
        chk("inf_sticky", 32'(b0.sticky_flags), 32'b11100);

        // Backpressure: third entry must wait upstream until a slot frees
        out_ready = 1'b0;
        drive(1'b1, 32'h3f800000, 32'h3f800000, 32'h40400000); cycle();
        drive(1'b1, 32'h3f800000, 32'h3f800000, 32'hc1200000); cycle();
        chk("full_in_ready", 32'(b0.in_ready), 32'd0);
        drive(1'b1, 32'h3f800000, 32'h00000000, 32'h00000000);
        cycle(); cycle();
        chk("held_head", b0.out_z, 32'h40400000);
        out_ready = 1'b1;
        push_held(32'h3f800000, 32'h00000000, 32'h00000000);
        for (int i = 0; i < 3; i++) cycle();

        // NaN payload: canonicalised on dut0, raw on dut1; sNaN operand raises invalid
        drive(1'b1, 32'h3f800000, 32'h3f800000, 32'hffc00001);
        cycle();
        chk("canon_z0", b0.out_z, 32'h7fc00000);
        chk("raw_z1", b1.out_z, 32'hffc00001);
        chk("nan_flags", 32'(b0.out_flags), 32'b01000);
        drive(1'b1, 32'h7f800001, 32'h3f800000, 32'h7fc00000);
        cycle();
        chk("snan_invalid", 32'(b0.out_flags[4]), 32'd1);
        in_valid = 1'b0;
        cycle();

        // Clear coincident with a NaN pop: the set wins
        out_ready = 1'b0;
        drive(1'b1, 32'h3f800000, 32'h3f800000, 32'hffc00001);
        cycle();
        in_valid = 1'b0; clr_sticky = 1'b1; out_ready = 1'b1;
        cycle();
        clr_sticky = 1'b0;
        chk("clr_set_sticky", 32'(b0.sticky_flags), 32'b01000);
        chk("clr_set_count", 32'(b0.nan_count), 32'd1);

        // Saturation: 5 NaNs on a 2-bit counter
        clr_sticky = 1'b1; cycle(); clr_sticky = 1'b0;
        drive(1'b1, 32'h3f800000, 32'h3f800000, 32'h7fc00000);
        for (int i = 0; i < 5; i++) cycle();
        in_valid = 1'b0;
        cycle(); cycle();
        chk("sat_count1", 32'(b1.nan_count), 32'd3);
        chk("sat_count0", 32'(b0.nan_count), 32'd5);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), rnd_fp(), rnd_fp(), rnd_fp());
            out_ready  = 1'($urandom_range(0, 2) != 0);
            clr_sticky = ($urandom_range(0, 19) == 0);
            cycle();
        end
        clr_sticky = 1'b0;

        // Asynchronous reset with two entries buffered
        out_ready = 1'b0;
        drive(1'b1, 32'h3f800000, 32'h7f800000, 32'h7f800000); cycle();
        drive(1'b1, 32'h3f800000, 32'h3f800000, 32'h7fc00000); cycle();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        q.delete(); m_sticky = '0; m_cnt0 = 0; m_cnt1 = 0;
        check_all();
        chk("rst_out_z0", b0.out_z, 32'd0);
        cycle();
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'h3fc00000, 32'h40000000, 32'h40400000);
        cycle();
        chk("post_rst_z", b0.out_z, 32'h40400000);
        chk("post_rst_valid", 32'(b0.out_valid), 32'd1);
        in_valid = 1'b0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp32mul_out_stage.md
Name: fp32mul_out_stage

Overview:
- Registered output stage placed directly downstream of the combinational single-cycle FP32 multiplier (fp32mulsc).
- Captures each product together with its operands and classifies the result as NaN, Inf, zero, denormal or invalid-operation.
- Optionally canonicalises NaNs, then presents the result on a valid/ready interface through a 2-entry skid buffer.
- Keeps sticky exception flags and a saturating NaN counter for software and debug readout.

Parameters:
- CANON_NAN, 1, when 1 every NaN result is replaced by 32'h7fc00000; when 0 the NaN passes through unchanged.
- CNT_W, 8, width of the saturating nan_count counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_a, in_b and in_z are valid.
- in_ready  output  1  stage can accept an entry this cycle.
- in_a  input  32  multiplier operand a.
- in_b  input  32  multiplier operand b.
- in_z  input  32  multiplier product z.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  consumer accepts the head entry.
- out_z  output  32  result, canonicalised if CANON_NAN=1.
- out_flags  output  5  per-result flags {invalid, nan, inf, zero, denorm}.
- clr_sticky  input  1  synchronous one-cycle clear of sticky_flags and nan_count.
- sticky_flags  output  5  OR of out_flags over all delivered results.
- nan_count  output  CNT_W  count of delivered NaN results; saturating.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Buffer is emptied; the in-flight entry is dropped.
  - out_valid=0, out_z=0, out_flags=0, sticky_flags=0, nan_count=0.
  - in_ready=1 (in_ready is decoded from occupancy, so it reads 1 both during and after reset).
- Buffer:
  - 2-entry FIFO holding {z, flags}; occupancy is 0, 1 or 2.
  - in_ready = (occupancy != 2), driven from registered state only, with no combinational path from out_ready.
  - Push on in_valid & in_ready; pop on out_valid & out_ready.
  - Push and pop in the same cycle leave occupancy unchanged.
  - Strict FIFO order is maintained.
- Latency: an entry accepted at edge N appears on out_valid/out_z right after edge N, provided the buffer was empty.
- Throughput: 1 result per cycle while out_ready=1.
- out_z, out_flags and out_valid are held stable while out_valid=1 and out_ready=0.
- Flag classification is computed at push from in_z (exponent E = z[30:23], mantissa M = z[22:0]):
  - nan = (E==FF) & (M!=0)
  - inf = (E==FF) & (M==0)
  - zero = (E==0) & (M==0)
  - denorm = (E==0) & (M!=0)
  - invalid = (a is Inf & b is ±0) | (a is ±0 & b is Inf) | a is sNaN | b is sNaN.
  - An sNaN has E==FF, M!=0 and bit 22 = 0.
- Canonicalisation: if CANON_NAN=1 and nan=1, the stored z is 32'h7fc00000. Flags are always computed from the raw in_z.
- Sticky flags and counter (update on a pop only, i.e. on delivered results):
  - sticky_next = (clr_sticky ? 0 : sticky) | (pop ? head_flags : 0). A set in the same cycle as a clear wins.
  - nan_count_next = (clr_sticky ? 0 : nan_count) + (pop & head_nan).
  - nan_count saturates at 2^CNT_W-1 and never wraps.
- Boundaries:
  - Buffer full with out_ready=0: in_ready=0; upstream data is held and not sampled.
  - Buffer full with out_ready=1: one pop occurs; in_ready stays 0 this cycle and rises the next cycle.
  - Buffer empty: out_valid=0 and out_z holds its last value. The consumer must qualify out_z with out_valid.
  - in_valid with in_ready=0 has no effect.

Test Plan:
- Basic: push a=3fc00000, b=40000000, z=40400000 with out_ready=1 -> out_valid rises 1 cycle later, out_z=40400000, out_flags=00000, sticky_flags=00000.
- Invalid: push a=7f800000, b=00000000, z=7fc00000 -> out_flags=11000, sticky_flags=11000, nan_count=1. Then push a=ff800000, b=40400000, z=ff800000 -> flags=00100, sticky_flags=11100.
- Backpressure: hold out_ready=0 and push z=40400000, c1200000, 00000000 on consecutive cycles -> in_ready=0 after the second push and the third entry is held upstream. Release out_ready -> outputs appear in order 40400000, c1200000, 00000000, 1 per cycle, with no loss or duplication.
- NaN handling: with CANON_NAN=1, push z=ffc00001 -> out_z=7fc00000, flags=01000. With CANON_NAN=0, the same push -> out_z=ffc00001. Push a=7f800001 (sNaN) -> invalid=1.
- Sticky and counter: assert clr_sticky in the same cycle a NaN result pops -> sticky_flags=01000, nan_count=1. With CNT_W=2, deliver 5 NaNs -> nan_count saturates at 3.
- Reset mid-operation: with 2 entries buffered, assert rst_n=0 asynchronously -> out_valid=0, in_ready=1, sticky_flags=0 and nan_count=0 immediately. After release, the next push behaves exactly as the Basic case.
